// File: rtl/cla_share_sched_pkg.sv
// Shared types and widths for the CLA sharing scheduler.
// Imported by the interface, the arbiter, the adder and the top.
package cla_sched_pkg;

  localparam int WORD_W   = 32;
  localparam int DWORD_W  = 64;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC_LO = 2'd1,
    EXEC_HI = 2'd2,
    RESP    = 2'd3
  } sched_state_e;

endpackage

// File: rtl/cla_share_sched_if.sv
// Request/response bundle between the adder clients and the shared-adder scheduler.
// master = requesters plus response consumer, slave = the scheduler.
interface cla_share_sched_if
  import cla_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*DWORD_W-1:0] req_a;
  logic [NREQ*DWORD_W-1:0] req_b;
  logic [NREQ-1:0]         req_cin;
  logic [NREQ-1:0]         req_wide;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [DWORD_W-1:0]      rsp_sum;
  logic                    rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_wide, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_wide, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/cla_32bits.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries resolved from
// group generate/propagate terms.
module cla_32bits
  import cla_sched_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  localparam int NGRP = WORD_W / 4;

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] c;
  logic [NGRP-1:0]   gg;
  logic [NGRP-1:0]   gp;
  logic [NGRP:0]     cg;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    localparam int B = 4 * gi;
    assign c[B]   = cg[gi];
    assign c[B+1] = g[B] | (p[B] & cg[gi]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & cg[gi]);
    assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[gi] = &p[B+3:B];
  end

  always_comb begin : p_grp_carry
    logic carry;
    carry = cin_i;
    for (int k = 0; k < NGRP; k++) begin
      cg[k] = carry;
      carry = gg[k] | (gp[k] & carry);
    end
    cg[NGRP] = carry;
  end

  assign sum_o  = p ^ c;
  assign cout_o = cg[NGRP];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester found searching upward (with wrap) from ptr_i+1.
// Purely combinational; grant is forced to zero when en_i is low.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW-1:0]  cand [NREQ];
  logic [NREQ-1:0] hit;
  logic [IDW-1:0]  sel_idx;

  // cand[k] is the index visited at search step k+1 after the pointer
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand[gi] = IDW'((32'(ptr_i) + 32'(gi) + 32'd1) % NREQ);
    assign hit[gi]  = req_i[cand[gi]];
  end

  always_comb begin
    sel_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel_idx = cand[k];
      end
    end
  end

  assign idx_o = sel_idx;
  assign gnt_o = (en_i && (|hit)) ? (NREQ'(1) << sel_idx) : '0;

endmodule

// File: rtl/cla_share_sched.sv
// Shares one 32-bit CLA among NREQ requesters; 64-bit adds run as two chained passes
// through the same adder, results are held in a back-pressurable response register.
module cla_share_sched
  import cla_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  cla_share_sched_if.slave  bus,
  output logic              busy
);

  localparam int IDW = $clog2(NREQ);

  sched_state_e       state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [DWORD_W-1:0] a_q, a_d;
  logic [DWORD_W-1:0] b_q, b_d;
  logic [DWORD_W-1:0] sum_q, sum_d;
  logic               cin_q, cin_d;
  logic               wide_q, wide_d;
  logic               cout_q, cout_d;

  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               arb_en;

  logic [DWORD_W-1:0] lane_a [NREQ];
  logic [DWORD_W-1:0] lane_b [NREQ];

  logic               hi_pass;
  logic [WORD_W-1:0]  add_a, add_b, add_sum;
  logic               add_cin, add_cout;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign lane_a[gi] = bus.req_a[gi*DWORD_W +: DWORD_W];
    assign lane_b[gi] = bus.req_b[gi*DWORD_W +: DWORD_W];
  end

  assign arb_en = (state_q == IDLE);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (last_grant_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // The low-pass carry sits in cout_q and feeds the high pass as its carry-in
  assign hi_pass = (state_q == EXEC_HI);
  assign add_a   = hi_pass ? a_q[DWORD_W-1:WORD_W] : a_q[WORD_W-1:0];
  assign add_b   = hi_pass ? b_q[DWORD_W-1:WORD_W] : b_q[WORD_W-1:0];
  assign add_cin = hi_pass ? cout_q : cin_q;

  cla_32bits u_cla (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    cin_d        = cin_q;
    wide_d       = wide_q;
    cout_d       = cout_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          a_d          = lane_a[gnt_idx];
          b_d          = lane_b[gnt_idx];
          cin_d        = bus.req_cin[gnt_idx];
          wide_d       = bus.req_wide[gnt_idx];
          id_d         = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = EXEC_LO;
        end
      end
      EXEC_LO: begin
        sum_d[WORD_W-1:0]       = add_sum;
        sum_d[DWORD_W-1:WORD_W] = '0;
        cout_d                  = add_cout;
        state_d                 = wide_q ? EXEC_HI : RESP;
      end
      EXEC_HI: begin
        sum_d[DWORD_W-1:WORD_W] = add_sum;
        cout_d                  = add_cout;
        state_d                 = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      cin_q        <= 1'b0;
      wide_q       <= 1'b0;
      cout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      cin_q        <= cin_d;
      wide_q       <= wide_d;
      cout_q       <= cout_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cla_share_sched.sv
// Directed bench for cla_share_sched: carries, 32/64-bit latency, round-robin order,
// response back-pressure and asynchronous reset in flight.
module tb_cla_share_sched;
  import cla_sched_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  cla_share_sched_if #(.NREQ(NREQ)) bus ();

  cla_share_sched #(.NREQ(NREQ)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE; runs one op to retirement.
  task automatic run_op(input string tag, input logic [NREQ-1:0] vmask, input int idx,
                        input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic wide, input logic [63:0] exp_sum, input logic exp_cout,
                        input int hold);
    logic [NREQ-1:0] bit_m;
    bit_m = NREQ'(1) << idx;
    bus.req_a[idx*64 +: 64] = a;
    bus.req_b[idx*64 +: 64] = b;
    bus.req_cin[idx]        = cin;
    bus.req_wide[idx]       = wide;
    bus.req_valid           = vmask;
    #1;
    check({tag, ".grant"}, bus.req_ready, bit_m);
    @(posedge clk); #1;
    bus.req_valid = vmask & ~bit_m;
    check({tag, ".exec_lo"}, {busy, bus.rsp_valid}, 2'b10);
    if (wide) begin
      @(posedge clk); #1;
      check({tag, ".exec_hi"}, {busy, bus.rsp_valid}, 2'b10);
    end
    @(posedge clk); #1;
    for (int h = 0; h < hold; h++) begin
      check({tag, ".hold_valid"}, bus.rsp_valid, 1'b1);
      check({tag, ".hold_sum"}, bus.rsp_sum, exp_sum);
      check({tag, ".hold_cout"}, bus.rsp_cout, exp_cout);
      check({tag, ".hold_ready"}, bus.req_ready, '0);
      @(posedge clk); #1;
    end
    check({tag, ".rsp_valid"}, bus.rsp_valid, 1'b1);
    check({tag, ".rsp_id"}, bus.rsp_id, 64'(idx));
    check({tag, ".rsp_sum"}, bus.rsp_sum, exp_sum);
    check({tag, ".rsp_cout"}, bus.rsp_cout, exp_cout);
    check({tag, ".rsp_req_ready"}, bus.req_ready, '0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, ".retired"}, {busy, bus.rsp_valid}, 2'b00);
  endtask

  int order [6] = '{0, 1, 2, 3, 0, 1};
  int grants;
  int rsp_seen;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_wide  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst.rsp_valid", bus.rsp_valid, 1'b0);
    check("rst.rsp_sum", bus.rsp_sum, 64'h0);
    check("rst.rsp_cout", bus.rsp_cout, 1'b0);
    check("rst.rsp_id", bus.rsp_id, 64'h0);
    check("rst.busy", busy, 1'b0);
    check("rst.req_ready", bus.req_ready, '0);
    rst = 1'b0;

    // Carry and width cases
    run_op("A", 4'b0001, 0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 0);
    run_op("C", 4'b0100, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 64'h0, 1'b1, 0);
    run_op("B", 4'b0100, 2, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1,
           64'h0000_0001_0000_0000, 1'b0, 0);
    run_op("E", 4'b0001, 0, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0001, 1'b1, 1'b0,
           64'h0000_0000_8000_0001, 1'b0, 0);

    // Back-pressure for 5 cycles with requester 0 pending
    run_op("D", 4'b1001, 3, 64'h8000_0001, 64'h8000_0002, 1'b1, 1'b0, 64'h4, 1'b1, 5);
    check("D.next_grant", bus.req_ready, 4'b0001);
    bus.req_valid = '0;

    // All requesters continuously valid, consumer always ready
    bus.req_wide  = '0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    grants   = 0;
    rsp_seen = 0;
    for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
      #1;
      check("rr.onehot", 64'($countones(bus.req_ready) <= 1), 64'h1);
      if (bus.rsp_valid && rsp_seen < 6) begin
        check("rr.rsp_id", bus.rsp_id, 64'(order[rsp_seen]));
        rsp_seen++;
      end
      if (bus.req_ready != '0) begin
        check("rr.order", bus.req_ready, 64'(1 << order[grants]));
        grants++;
      end
      if (grants < 6) begin
        @(posedge clk); #1;
      end
    end
    check("rr.grants", grants, 6);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("rr.drained", busy, 1'b0);

    // After a grant to 1, requesters 1 and 3 valid: 3 first, then 1
    run_op("F3", 4'b1010, 3, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 1'b0, 1'b1,
           64'h0000_0003_0000_0000, 1'b0, 0);
    check("F.next_grant", bus.req_ready, 4'b0010);
    run_op("F1", 4'b0010, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    bus.req_valid = '0;

    // Asynchronous reset while requester 0's 64-bit op is in EXEC_HI
    bus.req_a[0 +: 64] = 64'h0000_0001_0000_0005;
    bus.req_b[0 +: 64] = 64'h3;
    bus.req_cin[0]     = 1'b0;
    bus.req_wide[0]    = 1'b1;
    bus.req_valid      = 4'b0001;
    #1;
    check("R.grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    check("R.in_hi", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("R.busy", busy, 1'b0);
    check("R.rsp_valid", bus.rsp_valid, 1'b0);
    check("R.rsp_sum", bus.rsp_sum, 64'h0);
    check("R.rsp_cout", bus.rsp_cout, 1'b0);
    check("R.rsp_id", bus.rsp_id, 64'h0);
    check("R.req_ready", bus.req_ready, '0);
    #2;
    rst = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    check("R.next_grant", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    check("R.no_rsp", {busy, bus.rsp_valid}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
